// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-8 Booth recoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT
  } state_t;

  localparam int unsigned WIN_W = 4;

  function automatic int unsigned booth_ndigits(input int unsigned m);
    return (m + 2) / 3;
  endfunction

  // Digit value of a window: -4*w3 + 2*w2 + w1 + w0, always in -4..+4.
  function automatic logic signed [3:0] booth_digit(input logic [WIN_W-1:0] w);
    logic signed [3:0] d;
    d = (w[3] ? -4'sd4 : 4'sd0)
      + (w[2] ?  4'sd2 : 4'sd0)
      + $signed({3'b000, w[1]})
      + $signed({3'b000, w[0]});
    return d;
  endfunction

endpackage

// File: rtl/booth_r8_recoder_if.sv
// Operand-in / Booth-digit-out channels of the recoder.
// master: the recoder; slave: the operand source and digit consumer.
interface booth_r8_recoder_if #(
  parameter int unsigned M = 4
);
  import booth_pkg::*;

  localparam int unsigned G  = booth_ndigits(M);
  localparam int unsigned IW = $clog2(G + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [M-1:0]            in_x;
  logic [M-1:0]            in_y;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIN_W-1:0]        out_win;
  logic signed [3:0]       out_digit;
  logic [M-1:0]            out_x;
  logic [M+1:0]            out_tx;
  logic [IW-1:0]           out_idx;
  logic                    out_last;

  modport master (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_win, out_digit, out_x, out_tx, out_idx, out_last
  );

  modport slave (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_win, out_digit, out_x, out_tx, out_idx, out_last
  );

endinterface

// File: rtl/booth_r8_digit.sv
// Combinational window-to-digit decoder with zero flag.
module booth_r8_digit
  import booth_pkg::*;
(
  input  logic [WIN_W-1:0] win,
  output logic signed [3:0] digit,
  output logic              is_zero
);

  // Decode the current window.
  always_comb begin
    digit   = booth_digit(win);
    is_zero = (digit == 4'sd0);
  end

endmodule

// File: rtl/booth_r8_recoder.sv
// Sequential radix-8 Booth recoder: captures x and y, computes 3x, then
// streams one 4-bit window per digit with its value, x and 3x.
// Optional build macro: BOOTH_R8_ZERO_SKIP_EN (skip zero digits except the last).
module booth_r8_recoder
  import booth_pkg::*;
#(
  parameter int unsigned M = 4
) (
  input logic               clk,
  input logic               rst,
  booth_r8_recoder_if.master bus
);

  localparam int unsigned G  = booth_ndigits(M);
  localparam int unsigned IW = $clog2(G + 1);
  localparam int unsigned YS = 3 * G;
  localparam int unsigned TW = M + 2;

  state_t               state, state_nxt;
  logic [YS:0]          y_ext;
  logic [M-1:0]         x_reg;
  logic [TW-1:0]        tx_reg;
  logic [IW-1:0]        idx, idx_first;
  logic signed [YS-1:0] y_sx;
  logic signed [TW-1:0] x_sx;
  logic [WIN_W-1:0]     win;
  logic signed [3:0]    digit;
  logic                 digit_zero;
  logic                 accept, advance, last;
  int unsigned          base;

  assign y_sx    = YS'(signed'(bus.in_y));
  assign x_sx    = TW'(signed'(x_reg));
  assign win     = WIN_W'(y_ext >> (3 * int'(idx)));
  assign last    = (idx == IW'(G - 1));
  assign accept  = bus.in_valid & bus.in_ready;
  assign advance = (state == EMIT) & bus.out_ready;

  booth_r8_digit u_digit (
    .win     (win),
    .digit   (digit),
    .is_zero (digit_zero)
  );

  // Next digit position to present: from 0 on load, else the one after idx.
  always_comb begin
    base      = (state == LOAD) ? 0 : int'(idx) + 1;
    idx_first = IW'(base);
`ifdef BOOTH_R8_ZERO_SKIP_EN
    // Scan downward so the lowest qualifying position wins; the final digit
    // always qualifies so out_last is still seen.
    idx_first = IW'(G - 1);
    for (int unsigned k = 0; k < G; k++) begin
      if ((G - 1 - k) >= base &&
          ((G - 1 - k) == G - 1 ||
           booth_digit(WIN_W'(y_ext >> (3 * (G - 1 - k)))) != 4'sd0))
        idx_first = IW'(G - 1 - k);
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and outputs.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_win   = '0;
    bus.out_digit = '0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.out_x     = x_reg;
    bus.out_tx    = tx_reg;
    unique case (state)
      IDLE: begin
        bus.in_ready = ~rst;
        if (accept) state_nxt = LOAD;
      end
      LOAD: state_nxt = EMIT;
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_win   = win;
        bus.out_digit = digit_zero ? 4'sd0 : digit;
        bus.out_idx   = idx;
        bus.out_last  = last;
        if (advance && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, 3x precompute and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg  <= '0;
      y_ext  <= '0;
      tx_reg <= '0;
      idx    <= '0;
    end else begin
      if (accept) begin
        x_reg <= bus.in_x;
        y_ext <= {y_sx, 1'b0};
      end
      if (state == LOAD) begin
        tx_reg <= (x_sx <<< 1) + x_sx;
        idx    <= idx_first;
      end
      if (advance && !last) idx <= idx_first;
    end
  end

endmodule

// File: tb/tb_booth_r8_recoder.sv
// Scoreboard bench for booth_r8_recoder (M=4, G=2).
module tb_booth_r8_recoder;
  import booth_pkg::*;

  localparam int unsigned M = 4;
  localparam int unsigned G = 2;

  typedef struct packed {
    logic [3:0] win;
    logic [3:0] digit;
    logic [3:0] x;
    logic [5:0] tx;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_r8_recoder_if #(.M(M)) bus ();
  booth_r8_recoder #(.M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

  beat_t exp_q[$];
  int    y_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [3:0] w, input logic [3:0] d, input logic [3:0] x,
                               input logic [5:0] tx, input logic [1:0] i, input logic l);
    beat_t b;
    b.win = w; b.digit = d; b.x = x; b.tx = tx; b.idx = i; b.last = l;
    return b;
  endfunction

  function automatic beat_t cur_beat();
    return mk(bus.out_win, bus.out_digit, bus.out_x, bus.out_tx, bus.out_idx, bus.out_last);
  endfunction

  // Monitor: compare every accepted beat with the scoreboard and the running sum with y.
  beat_t mon_act, mon_exp;
  int    sum = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) sum = 0;
      else if (bus.out_valid && bus.out_ready) begin
        mon_act = cur_beat();
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %h expected none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          check("beat", 32'(mon_act), 32'(mon_exp));
        end
        sum += int'($signed(bus.out_digit)) * (8 ** int'(bus.out_idx));
        if (bus.out_last) begin
          if (y_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sum_unexpected: got %0d expected none", sum);
          end else check("sum_eq_y", 32'(sum), 32'(y_q.pop_front()));
          sum = 0;
        end
      end
    end
  end

  // Offer an operand pair; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    bus.in_x = x; bus.in_y = y; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) check("accept_timeout", 32'(n), 32'd0);
    y_q.push_back(int'($signed(y)));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(exp_q.size() == 0 && bus.in_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("done_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("valid_seen", 32'(bus.out_valid), 32'd1);
  endtask

  // Reference beats from the window definition.
  task automatic model(input logic [3:0] x, input logic [3:0] y);
    logic signed [5:0] ys;
    logic [6:0] ye;
    logic [3:0] w;
    logic [5:0] tx;
    int d;
    ys = 6'($signed(y));
    ye = {ys, 1'b0};
    tx = 6'(3 * int'($signed(x)));
    for (int i = 0; i < int'(G); i++) begin
      w = 4'(ye >> (3 * i));
      d = -4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
`ifdef BOOTH_R8_ZERO_SKIP_EN
      if (d == 0 && i != int'(G) - 1) continue;
`endif
      exp_q.push_back(mk(w, 4'(d), x, tx, 2'(i), i == int'(G) - 1));
    end
  endtask

  beat_t snap;
  int    n;

  initial begin
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b1;

    // Reset state
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_outs", 32'({bus.out_valid, cur_beat()}), 32'd0);
    @(posedge clk); #1; rst = 1'b0; #1;
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // x=5, y=3 with latency and throughput
    exp_q.push_back(mk(4'b0110, 4'd3, 4'd5, 6'd15, 2'd0, 1'b0));
    exp_q.push_back(mk(4'b0000, 4'd0, 4'd5, 6'd15, 2'd1, 1'b1));
    send(4'd5, 4'd3);
    check("latency_load", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("latency_first", 32'(bus.out_valid), 32'd1);
    n = 1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("reaccept_cycles", 32'(n), 32'(G + 1));
    wait_done();

    // x=-3, y=-1
    exp_q.push_back(mk(4'b1110, 4'hF, 4'hD, 6'b110111, 2'd0, 1'b0));
    exp_q.push_back(mk(4'b1111, 4'h0, 4'hD, 6'b110111, 2'd1, 1'b1));
    send(4'hD, 4'hF);
    wait_done();

    // x=7, y=-8
`ifndef BOOTH_R8_ZERO_SKIP_EN
    exp_q.push_back(mk(4'b0000, 4'h0, 4'd7, 6'd21, 2'd0, 1'b0));
`endif
    exp_q.push_back(mk(4'b1110, 4'hF, 4'd7, 6'd21, 2'd1, 1'b1));
    send(4'd7, 4'h8);
    wait_done();

    // Backpressure on beat 0, with ignored in_valid pulses
    bus.out_ready = 1'b0;
    exp_q.push_back(mk(4'b0110, 4'd3, 4'd5, 6'd15, 2'd0, 1'b0));
    exp_q.push_back(mk(4'b0000, 4'd0, 4'd5, 6'd15, 2'd1, 1'b1));
    send(4'd5, 4'd3);
    wait_valid();
    snap = cur_beat();
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = (k != 1); bus.in_x = 4'd1; bus.in_y = 4'd1;
      @(posedge clk); #1;
      check("bp_hold", 32'({bus.out_valid, cur_beat()}), 32'({1'b1, snap}));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_done();

    // Reset mid-EMIT after beat 0
    bus.out_ready = 1'b0;
    exp_q.push_back(mk(4'b0110, 4'd3, 4'd5, 6'd15, 2'd0, 1'b0));
    exp_q.push_back(mk(4'b0000, 4'd0, 4'd5, 6'd15, 2'd1, 1'b1));
    send(4'd5, 4'd3);
    wait_valid();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete(); y_q.delete();
    #1;
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1; rst = 1'b0; #1;
    check("rst_mid_release", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(mk(4'b1110, 4'hF, 4'd2, 6'd6, 2'd0, 1'b0));
    exp_q.push_back(mk(4'b0001, 4'd1, 4'd2, 6'd6, 2'd1, 1'b1));
    send(4'd2, 4'd7);
    wait_done();

    // All operand pairs
    for (int xi = -8; xi < 8; xi++) begin
      for (int yi = -8; yi < 8; yi++) begin
        model(4'(xi), 4'(yi));
        send(4'(xi), 4'(yi));
      end
    end
    wait_done();
    check("queue_empty", 32'(exp_q.size() + y_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
